// File: rtl/klt_pkg.sv
// klt_pkg: shared KLT widths, solver state encoding and the signed sum type.
package klt_pkg;
  localparam int SUM_W = 32;
  localparam int FRAC = 29;
  localparam int INT_Q = 5;
  localparam int OUT_W = 88;
  localparam int MAX_DISP = 8;
  localparam int MIN_DET = 64;
  localparam int PROD_W = 2 * SUM_W;
  localparam int DET_W = PROD_W + 1;
  localparam int Q_W = INT_Q + FRAC;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef enum logic [2:0] {IDLE, MUL, COMB, DIV, FIN} solver_state_t;
  function automatic logic [OUT_W-1:0] apply_sign(input logic neg, input logic [Q_W-1:0] mag);
    logic [OUT_W-1:0] ext;
    ext = OUT_W'(mag);
    return neg ? -ext : ext;
  endfunction
endpackage

// File: rtl/klt_seq_divider.sv
// klt_seq_divider: unsigned restoring divider, one quotient bit per clock.
module klt_seq_divider #(
  parameter int DVD_W = 94,
  parameter int DIV_W = 65,
  parameter int Q_W = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             done
);
  localparam int CW = $clog2(Q_W + 1);
  logic [DIV_W-1:0] rem;
  logic [Q_W-1:0] q;
  logic [CW-1:0] cnt;
  logic [DIV_W:0] trial;
  logic ge;
  assign trial = {rem, q[Q_W-1]};
  assign ge = trial >= {1'b0, divisor};
  // high during the last iteration so the quotient is complete after this edge
  assign done = cnt == CW'(1);
  assign quotient = q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem <= '0;
      q <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= DIV_W'(dividend[DVD_W-1:Q_W]);
      q <= dividend[Q_W-1:0];
      cnt <= CW'(Q_W);
    end else if (cnt != '0) begin
      rem <= ge ? DIV_W'(trial - {1'b0, divisor}) : trial[DIV_W-1:0];
      q <= {q[Q_W-2:0], ge};
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/klt_displacement_solver.sv
// klt_displacement_solver: solves G*d = -b by Cramer's rule for sub-pixel
// ROI displacement, with degenerate detection and clamping.
module klt_displacement_solver
  import klt_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sums_valid,
  input  sum_t                    sxx,
  input  sum_t                    syy,
  input  sum_t                    sxy,
  input  sum_t                    sxt,
  input  sum_t                    syt,
  output logic                    busy,
  output logic signed [OUT_W-1:0] dx,
  output logic signed [OUT_W-1:0] dy,
  output logic                    d_ready,
  output logic                    degenerate,
  output logic                    saturated,
  output logic                    dropped
);
  localparam logic [Q_W-1:0] CLAMP = Q_W'(MAX_DISP) << FRAC;
  solver_state_t state, nxt;
  sum_t xx, yy, xy, xt, yt;
  logic signed [PROD_W-1:0] p_xxyy, p_xyxy, p_xyyt, p_yyxt, p_xyxt, p_xxyt;
  logic signed [DET_W-1:0] det_c, nx_c, ny_c;
  logic [DET_W-1:0] anx_c, any_c;
  logic deg_c, ovx_c, ovy_c, deg_r, sx_r, sy_r, ovx_r, ovy_r;
  logic start, done_x, done_y, satx, saty;
  logic [Q_W-1:0] qx, qy, magx, magy;
  assign busy = state != IDLE;
  always_comb begin
    det_c = DET_W'(p_xxyy) - DET_W'(p_xyxy);
    nx_c = DET_W'(p_xyyt) - DET_W'(p_yyxt);
    ny_c = DET_W'(p_xyxt) - DET_W'(p_xxyt);
    anx_c = nx_c[DET_W-1] ? -nx_c : nx_c;
    any_c = ny_c[DET_W-1] ? -ny_c : ny_c;
    deg_c = det_c < $signed(DET_W'(MIN_DET));
    // a quotient that would not fit in INT_Q integer bits is clamped, not divided
    ovx_c = {INT_Q'(0), anx_c} >= {det_c, INT_Q'(0)};
    ovy_c = {INT_Q'(0), any_c} >= {det_c, INT_Q'(0)};
    start = state == COMB && !deg_c;
    satx = ovx_r || qx > CLAMP;
    saty = ovy_r || qy > CLAMP;
    magx = satx ? CLAMP : qx;
    magy = saty ? CLAMP : qy;
    nxt = state == IDLE ? (sums_valid ? MUL : IDLE) :
          state == MUL  ? COMB :
          state == COMB ? (deg_c ? FIN : DIV) :
          state == DIV  ? (done_x && done_y ? FIN : DIV) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      {xx, yy, xy, xt, yt} <= '0;
      {p_xxyy, p_xyxy, p_xyyt, p_yyxt, p_xyxt, p_xxyt} <= '0;
      {deg_r, sx_r, sy_r, ovx_r, ovy_r} <= '0;
      {dx, dy, d_ready, degenerate, saturated, dropped} <= '0;
    end else begin
      state <= nxt;
      d_ready <= 1'b0;
      dropped <= sums_valid && state != IDLE;
      if (state == IDLE && sums_valid) {xx, yy, xy, xt, yt} <= {sxx, syy, sxy, sxt, syt};
      if (state == MUL) begin
        p_xxyy <= PROD_W'(xx) * PROD_W'(yy);
        p_xyxy <= PROD_W'(xy) * PROD_W'(xy);
        p_xyyt <= PROD_W'(xy) * PROD_W'(yt);
        p_yyxt <= PROD_W'(yy) * PROD_W'(xt);
        p_xyxt <= PROD_W'(xy) * PROD_W'(xt);
        p_xxyt <= PROD_W'(xx) * PROD_W'(yt);
      end
      if (state == COMB) {deg_r, sx_r, sy_r, ovx_r, ovy_r} <= {deg_c, nx_c[DET_W-1], ny_c[DET_W-1], ovx_c, ovy_c};
      if (state == FIN) begin
        d_ready <= 1'b1;
        degenerate <= deg_r;
        saturated <= !deg_r && (satx || saty);
        dx <= deg_r ? '0 : apply_sign(sx_r, magx);
        dy <= deg_r ? '0 : apply_sign(sy_r, magy);
      end
    end
  end
  klt_seq_divider #(.DVD_W(DET_W + FRAC), .DIV_W(DET_W), .Q_W(Q_W)) u_div_x (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend({anx_c, FRAC'(0)}),
    .divisor(det_c), .quotient(qx), .done(done_x)
  );
  klt_seq_divider #(.DVD_W(DET_W + FRAC), .DIV_W(DET_W), .Q_W(Q_W)) u_div_y (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend({any_c, FRAC'(0)}),
    .divisor(det_c), .quotient(qy), .done(done_y)
  );
endmodule

// File: tb/tb_klt_displacement_solver.sv
// tb_klt_displacement_solver: directed vectors with hand-computed displacements.
module tb_klt_displacement_solver;
  import klt_pkg::*;
  logic clk = 0, rst_n = 0, sums_valid = 0;
  sum_t sxx = 0, syy = 0, sxy = 0, sxt = 0, syt = 0;
  logic busy, d_ready, degenerate, saturated, dropped;
  logic signed [OUT_W-1:0] dx, dy;
  int n_cmp = 0, n_bad = 0;
  klt_displacement_solver dut (
    .clk(clk), .rst_n(rst_n), .sums_valid(sums_valid), .sxx(sxx), .syy(syy),
    .sxy(sxy), .sxt(sxt), .syt(syt), .busy(busy), .dx(dx), .dy(dy),
    .d_ready(d_ready), .degenerate(degenerate), .saturated(saturated), .dropped(dropped)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start(input sum_t a, input sum_t b, input sum_t c, input sum_t d, input sum_t e);
    @(negedge clk);
    {sxx, syy, sxy, sxt, syt} = {a, b, c, d, e};
    sums_valid = 1;
    @(posedge clk);
    #1 sums_valid = 0;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1 n++;
      if (d_ready) break;
    end
  endtask
  int n, seen;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst dx", dx, 0);
    chk("rst dy", dy, 0);
    chk("rst d_ready", d_ready, 0);
    chk("rst degenerate", degenerate, 0);
    chk("rst saturated", saturated, 0);
    chk("rst dropped", dropped, 0);
    rst_n = 1;
    start(100, 100, 0, -150, 50);
    chk("t1 busy", busy, 1);
    wait_ready(n);
    chk("t1 latency", n, 37);
    chk("t1 dx", dx, 88'sd805306368);
    chk("t1 dy", dy, -88'sd268435456);
    chk("t1 degenerate", degenerate, 0);
    chk("t1 saturated", saturated, 0);
    @(posedge clk);
    #1 chk("t1 idle", busy, 0);
    chk("t1 pulse", d_ready, 0);
    start(5, 5, 5, 1, 1);
    wait_ready(n);
    chk("deg latency", n, 3);
    chk("deg dx", dx, 0);
    chk("deg dy", dy, 0);
    chk("deg flag", degenerate, 1);
    chk("deg saturated", saturated, 0);
    start(100, 100, 0, -5000, 0);
    wait_ready(n);
    chk("clamp latency", n, 37);
    chk("clamp dx", dx, 88'sd4294967296);
    chk("clamp dy", dy, 0);
    chk("clamp saturated", saturated, 1);
    chk("clamp degenerate", degenerate, 0);
    start(300, 200, 100, 100, 50);
    wait_ready(n);
    chk("trunc dx", dx, -88'sd161061273);
    chk("trunc dy", dy, -88'sd53687091);
    chk("trunc saturated", saturated, 0);
    start(100, 100, 0, -150, 50);
    repeat (9) @(posedge clk);
    @(negedge clk);
    {sxx, syy, sxy, sxt, syt} = {32'sd1, 32'sd1, 32'sd0, 32'sd1, 32'sd1};
    sums_valid = 1;
    @(posedge clk);
    #1 sums_valid = 0;
    chk("drop pulse", dropped, 1);
    chk("drop busy", busy, 1);
    @(posedge clk);
    #1 chk("drop single", dropped, 0);
    wait_ready(n);
    chk("drop latency", n, 26);
    chk("drop dx", dx, 88'sd805306368);
    chk("drop dy", dy, -88'sd268435456);
    start(100, 100, 0, -5000, 0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    chk("abort busy", busy, 0);
    chk("abort dx", dx, 0);
    chk("abort dy", dy, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (d_ready) seen++;
    end
    chk("abort no d_ready", seen, 0);
    start(100, 100, 0, -150, 50);
    wait_ready(n);
    chk("post latency", n, 37);
    chk("post dx", dx, 88'sd805306368);
    chk("post dy", dy, -88'sd268435456);
    start(200, 100, 0, 100, -300);
    chk("b2b accepted", busy, 1);
    chk("b2b not dropped", dropped, 0);
    wait_ready(n);
    chk("b2b latency", n, 37);
    chk("b2b dx", dx, -88'sd268435456);
    chk("b2b dy", dy, 88'sd1610612736);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
